// File: rtl/seq_addsub_pkg.sv
// rtl/seq_addsub_pkg.sv - shared FSM state type and constant helpers for the chunked adder
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Ceiling log2 evaluated at elaboration to size the chunk counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_addsub_rca_chunk.sv
// rtl/seq_addsub_rca_chunk.sv - combinational CHUNK-bit ripple-carry adder slice
module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  // c_msb is the carry entering the top bit; the top-level overflow needs it.
  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - multi-cycle add/subtract, CHUNK bits per cycle LSB first, start/done handshake
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_addsub: CHUNK must divide WIDTH");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] sum_chunk;
  logic             chunk_cout;
  logic             chunk_cmsb;
  logic [WIDTH-1:0] res_shift;
  logic             last;

  rca_chunk #(.CHUNK(CHUNK)) u_rca (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .cin   (carry_q),
    .s     (sum_chunk),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  assign last = (cnt_q == CW'(N - 1));

  // Each new chunk enters at the top, so after N shifts chunk 0 sits at bit 0.
  assign res_shift = (res_q >> CHUNK) | (WIDTH'(sum_chunk) << (WIDTH - CHUNK));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_cout;
        res_d   = res_shift;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          s_d     = res_shift;
          cout_d  = chunk_cout;
          ovf_d   = chunk_cmsb ^ chunk_cout;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// tb/tb_seq_addsub.sv - directed and randomised checks of seq_addsub for CHUNK=8,1,4,32
module tb_seq_addsub;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        cin, sub;

  logic [3:0]  bz, dn, co, ov;
  logic [31:0] sv [4];

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_s;

  seq_addsub #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(bz[0]), .done(dn[0]), .s(sv[0]), .cout(co[0]), .ovf(ov[0]));
  seq_addsub #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(bz[1]), .done(dn[1]), .s(sv[1]), .cout(co[1]), .ovf(ov[1]));
  seq_addsub #(.WIDTH(32), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(bz[2]), .done(dn[2]), .s(sv[2]), .cout(co[2]), .ovf(ov[2]));
  seq_addsub #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(bz[3]), .done(dn[3]), .s(sv[3]), .cout(co[3]), .ovf(ov[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input logic ts);
    a     = ta;
    b     = tb_;
    cin   = tc;
    sub   = ts;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // CHUNK=8 instance: three RUN cycles with s held, then done with the result.
  task automatic expect_done(input string tag, input logic [31:0] es, input logic ec, input logic eo);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk({tag, "_busy"}, 64'(bz[0]), 64'd1);
      chk({tag, "_nodone"}, 64'(dn[0]), 64'd0);
      chk({tag, "_shold"}, 64'(sv[0]), 64'(last_s));
    end
    @(posedge clk);
    #1;
    chk({tag, "_done"}, 64'(dn[0]), 64'd1);
    chk({tag, "_idle"}, 64'(bz[0]), 64'd0);
    chk({tag, "_s"}, 64'(sv[0]), 64'(es));
    chk({tag, "_cout"}, 64'(co[0]), 64'(ec));
    chk({tag, "_ovf"}, 64'(ov[0]), 64'(eo));
    last_s = es;
  endtask

  initial begin
    logic [32:0] full;
    logic [31:0] rb;
    logic        eovf;
    logic [3:0]  seen;
    int          lat [4];
    lat[0] = 4; lat[1] = 32; lat[2] = 8; lat[3] = 1;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bz[0]), 64'd0);
    chk("rst_done", 64'(dn[0]), 64'd0);
    chk("rst_s", 64'(sv[0]), 64'd0);
    chk("rst_cout", 64'(co[0]), 64'd0);
    chk("rst_ovf", 64'(ov[0]), 64'd0);
    last_s = 32'd0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    start_op(32'h3B9ACA07, 32'h3B9ACA07, 1'b0, 1'b0);
    expect_done("add_basic", 32'h7735940E, 1'b0, 1'b0);
    // Each following op is started in the DONE cycle of the previous one.
    start_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    expect_done("carry_ripple", 32'h00000000, 1'b1, 1'b0);
    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    expect_done("ovf_pos", 32'h80000000, 1'b0, 1'b1);
    start_op(32'h80000000, 32'h80000000, 1'b0, 1'b0);
    expect_done("ovf_neg", 32'h00000000, 1'b1, 1'b1);
    start_op(32'h00000005, 32'h00000007, 1'b0, 1'b1);
    expect_done("sub_borrow", 32'hFFFFFFFE, 1'b0, 1'b0);
    start_op(32'h80000000, 32'h00000001, 1'b0, 1'b1);
    expect_done("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1);
    start_op(32'h00000009, 32'h00000004, 1'b1, 1'b1);
    expect_done("sub_bin", 32'h00000004, 1'b1, 1'b0);

    @(posedge clk);
    #1;
    chk("after_done_idle", 64'(dn[0]), 64'd0);

    // Start pulse and operand changes during RUN must not disturb the op.
    start_op(32'h00001000, 32'h00000234, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1; a = 32'hDEADBEEF; b = 32'h12345678; sub = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign_busy", 64'(bz[0]), 64'd1);
    @(posedge clk);
    #1;
    chk("ign_nodone", 64'(dn[0]), 64'd0);
    @(posedge clk);
    #1;
    chk("ign_done", 64'(dn[0]), 64'd1);
    chk("ign_s", 64'(sv[0]), 64'h00001234);
    last_s = 32'h00001234;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("ign_single_done", 64'(dn[0]), 64'd0);
    end

    // Reset in RUN cycle 3 aborts the op without a done.
    start_op(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", 64'(bz[0]), 64'd0);
    chk("midrst_done", 64'(dn[0]), 64'd0);
    chk("midrst_s", 64'(sv[0]), 64'd0);
    chk("midrst_cout", 64'(co[0]), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("midrst_nodone", 64'(dn[0]), 64'd0);
    end

    // Random sweep over all four chunk sizes in parallel.
    for (int i = 0; i < 1000; i++) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      if (i % 16 == 0) a = 32'h7FFFFFFF;
      if (i % 16 == 1) b = 32'h80000000;
      rb   = b ^ {32{sub}};
      full = {1'b0, a} + {1'b0, rb} + 33'(cin ^ sub);
      eovf = (a[31] == rb[31]) && (full[31] != a[31]);
      start_op(a, b, cin, sub);
      seen = 4'b0000;
      for (int cyc = 1; cyc <= 40 && seen != 4'hF; cyc++) begin
        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
          if (dn[j] && !seen[j]) begin
            seen[j] = 1'b1;
            chk($sformatf("sweep%0d_lat", lat[j]), 64'(cyc), 64'(lat[j]));
            chk($sformatf("sweep%0d_s", lat[j]), 64'(sv[j]), 64'(full[31:0]));
            chk($sformatf("sweep%0d_cout", lat[j]), 64'(co[j]), 64'(full[32]));
            chk($sformatf("sweep%0d_ovf", lat[j]), 64'(ov[j]), 64'(eovf));
          end
        end
      end
      chk("sweep_all_done", 64'(seen), 64'hF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
